transmissor_ps2: RTL

Host-to-device PS/2 transmitter: sends one 8-bit command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-drain clock/data pair. It performs the inhibit and request-to-send sequence, shifts data out on device-generated clock edges, and checks the device ACK. It sits beside the PS/2 receiver on the same two pins and runs on the system clock. `busy` lets upper layers ignore receiver output while a transmission is in progress.

---
 rtl/transmissor_ps2_pkg.sv | 19 +
 rtl/transmissor_ps2_if.sv | 22 ++
 rtl/sincronizador_ps2.sv | 28 ++
 rtl/transmissor_ps2.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/transmissor_ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame length and parity helper.
// Also used by the PS/2 receiver on the same pins.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SHIFT,
      WAIT_IDLE
   } estado_t;

   localparam int PS2_FRAME_EDGES = 11;

   function automatic logic paridade_impar(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/transmissor_ps2_if.sv
// Command handshake between the upper layer and the PS/2 transmitter.
// master = upper layer, slave = transmitter.
interface transmissor_ps2_if;

   logic       send;
   logic [7:0] cmd;
   logic       ready;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output send, cmd,
      input  ready, busy, done, err
   );

   modport slave (
      input  send, cmd,
      output ready, busy, done, err
   );

endinterface

// File: rtl/sincronizador_ps2.sv
// Two-flop synchronizer for one PS/2 pin plus a falling-edge pulse.
// Resets to 1, the idle level of the open-drain bus.
module sincronizador_ps2 (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic sync,
   output logic fall
);

   logic meta;
   logic prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= pin;
         sync <= meta;
         prev <= sync;
      end
   end

   assign fall = prev & ~sync;

endmodule

// File: rtl/transmissor_ps2.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send,
// shift on device clock edges and ACK check.
module transmissor_ps2
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int RTS_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic                clk,
   input  logic                reset,
   transmissor_ps2_if.slave    bus,
   input  logic                clk_ps2_in,
   input  logic                data_in,
   output logic                clk_ps2_oe,
   output logic                data_oe
);

   localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ?
                          INHIBIT_CYCLES : RTS_CYCLES;
   localparam int MAXC  = (TIMEOUT_CYCLES > MAX_A) ?
                          TIMEOUT_CYCLES : MAX_A;
   localparam int CW    = $clog2(MAXC + 1);

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    ACK_EDGE = 4'(PS2_FRAME_EDGES - 1);

   estado_t       state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    nbit, nbit_n;
   logic [7:0]    byte_q, byte_n;
   logic          par, par_n;
   logic          ack, ack_n;
   logic          clk_oe_n, data_oe_n;
   logic          done_q, done_n;
   logic          err_q, err_n;
   logic          clk_sync, clk_fall;
   logic          data_sync;
   logic          rdy;
   logic          tmo;

   sincronizador_ps2 u_sync_clk (
      .clk   (clk),
      .reset (reset),
      .pin   (clk_ps2_in),
      .sync  (clk_sync),
      .fall  (clk_fall)
   );

   sincronizador_ps2 u_sync_data (
      .clk   (clk),
      .reset (reset),
      .pin   (data_in),
      .sync  (data_sync),
      .fall  ()
   );

   // done holds ready low for one more cycle
   assign rdy       = (state == IDLE) & ~done_q;
   assign bus.ready = rdy;
   assign bus.busy  = ~rdy;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign tmo       = (cnt >= TMO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         nbit       <= '0;
         byte_q     <= '0;
         par        <= 1'b0;
         ack        <= 1'b0;
         clk_ps2_oe <= 1'b0;
         data_oe    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         nbit       <= nbit_n;
         byte_q     <= byte_n;
         par        <= par_n;
         ack        <= ack_n;
         clk_ps2_oe <= clk_oe_n;
         data_oe    <= data_oe_n;
         done_q     <= done_n;
         err_q      <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      nbit_n    = nbit;
      byte_n    = byte_q;
      par_n     = par;
      ack_n     = ack;
      clk_oe_n  = clk_ps2_oe;
      data_oe_n = data_oe;
      done_n    = 1'b0;
      err_n     = 1'b0;

      unique case (state)
         IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (bus.send && !done_q) begin
               state_n  = INHIBIT;
               cnt_n    = '0;
               byte_n   = bus.cmd;
               par_n    = paridade_impar(bus.cmd);
               clk_oe_n = 1'b1;
            end
         end

         INHIBIT: begin
            if (cnt >= INH_LAST) begin
               state_n   = RTS;
               cnt_n     = '0;
               data_oe_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         RTS: begin
            if (cnt >= RTS_LAST) begin
               state_n  = SHIFT;
               cnt_n    = '0;
               nbit_n   = '0;
               clk_oe_n = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         SHIFT: begin
            cnt_n = cnt + 1'b1;
            if (clk_fall) begin
               nbit_n = nbit + 4'd1;
               unique case (1'b1)
                  (nbit < 4'd8): data_oe_n = ~byte_q[nbit[2:0]];
                  (nbit == 4'd8): data_oe_n = ~par;
                  (nbit == 4'd9): data_oe_n = 1'b0;
                  (nbit == ACK_EDGE): begin
                     ack_n   = ~data_sync;
                     state_n = WAIT_IDLE;
                     cnt_n   = '0;
                  end
                  default: ;
               endcase
            end else if (tmo) begin
               state_n   = IDLE;
               data_oe_n = 1'b0;
               done_n    = 1'b1;
               err_n     = 1'b1;
            end
         end

         WAIT_IDLE: begin
            cnt_n = cnt + 1'b1;
            if (clk_sync && data_sync) begin
               state_n = IDLE;
               done_n  = 1'b1;
               err_n   = ~ack;
            end else if (tmo) begin
               state_n   = IDLE;
               data_oe_n = 1'b0;
               done_n    = 1'b1;
               err_n     = 1'b1;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule
